// File: rtl/watch_pkg.sv
// Shared types, range limits and BCD helper for the watch time-keeping slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: bcd2_t, SEC_MAX, MIN_MAX, HR24_MAX, HR12_MIN, HR12_MAX, bcd_inc().
package watch_pkg;

  // Two BCD digits packed as {tens, ones}.
  typedef logic [7:0] bcd2_t;

  localparam bcd2_t SEC_MAX  = 8'h59;
  localparam bcd2_t MIN_MAX  = 8'h59;
  localparam bcd2_t HR24_MAX = 8'h23;
  localparam bcd2_t HR12_MIN = 8'h01;
  localparam bcd2_t HR12_MAX = 8'h12;

  // Plain BCD +1 without range limiting; callers handle the wrap themselves so
  // the result never needs to leave a legal digit range.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter running min_val..max with synchronous load.
// Latency: val updates on the clock edge where inc/load is sampled; wrap is combinational.
// Backpressure: none; every inc is applied (load has priority over inc).
// Ports: clk, rst (async active-high), inc, load, load_val, max, min_val -> val, wrap.
module bcd_mod_counter
  import watch_pkg::*;
#(
  parameter bcd2_t RST_VAL = 8'h00
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  load,
  input  bcd2_t load_val,
  input  bcd2_t max,
  input  bcd2_t min_val,
  output bcd2_t val,
  output logic  wrap
);

  // Carry out to the next stage: asserted in the same cycle the wrap is taken.
  assign wrap = inc & (val == max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= RST_VAL;
    end else if (load) begin
      val <= load_val;
    end else if (inc) begin
      val <= (val == max) ? min_val : bcd_inc(val);
    end
  end

endmodule

// File: rtl/watch_time_counter.sv
// Time-of-day keeper: advances BCD hh:mm:ss per slow-clock rising edge; set mode adjusts min/hr from debounced buttons.
// Latency: tick_lvl rise before edge N -> sec_bcd/sec_tick at edge N+2; button press applies ~DEBOUNCE_CYCLES+4 cycles after it settles.
// Backpressure: none; ticks are never lost in run mode, and are discarded while set mode is active.
// Ports: clk_27Mhz, rst (async active-high), tick_lvl, set_mode, inc_min, inc_hr -> sec_bcd, min_bcd, hr_bcd, sec_tick, pm.
// Build option: TWELVE_HOUR_EN selects the 12,01..11 hour range with a pm flag; otherwise 00..23 and pm tied 0.
module watch_time_counter
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int DB_W            = 19
) (
  input  logic       clk_27Mhz,
  input  logic       rst,
  input  logic       tick_lvl,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       sec_tick,
  output logic       pm
);

`ifdef TWELVE_HOUR_EN
  localparam bcd2_t HR_MAX = HR12_MAX;
  localparam bcd2_t HR_MIN = HR12_MIN;
  localparam bcd2_t HR_RST = HR12_MAX;
`else
  localparam bcd2_t HR_MAX = HR24_MAX;
  localparam bcd2_t HR_MIN = 8'h00;
  localparam bcd2_t HR_RST = 8'h00;
`endif

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Synchronisers. tick keeps a third stage so the rising edge is s2 & ~s3.
  logic [2:0] tick_sync;
  logic [1:0] set_sync;
  logic [1:0] min_sync;
  logic [1:0] hr_sync;

  always_ff @(posedge clk_27Mhz or posedge rst) begin
    if (rst) begin
      tick_sync <= '0;
      set_sync  <= '0;
      min_sync  <= '0;
      hr_sync   <= '0;
    end else begin
      tick_sync <= {tick_sync[1:0], tick_lvl};
      set_sync  <= {set_sync[0], set_mode};
      min_sync  <= {min_sync[0], inc_min};
      hr_sync   <= {hr_sync[0], inc_hr};
    end
  end

  logic tick;
  logic set_on;
  logic run_tick;

  assign tick     = tick_sync[1] & ~tick_sync[2];
  assign set_on   = set_sync[1];
  assign run_tick = tick & ~set_on;

  // Debouncers, index 0 = inc_min, index 1 = inc_hr. The counter only runs
  // while the synced level disagrees with the accepted state, so any bounce
  // shorter than DEBOUNCE_CYCLES restarts it. press is a single-cycle pulse
  // on an accepted 0->1 change, so a held button yields one press.
  logic [1:0]           btn_s2;
  logic [1:0]           db_state;
  logic [1:0]           press;
  logic [1:0][DB_W-1:0] db_cnt;

  assign btn_s2 = {hr_sync[1], min_sync[1]};

  always_ff @(posedge clk_27Mhz or posedge rst) begin
    if (rst) begin
      db_state <= '0;
      press    <= '0;
      db_cnt   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (btn_s2[i] == db_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_state[i] <= btn_s2[i];
          db_cnt[i]   <= '0;
          press[i]    <= btn_s2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Counter chain. The full 23:59:59 carry resolves combinationally through
  // the wrap outputs so all three digits pairs change on the same edge.
  // Minute presses never carry into hours because the hour carry term is
  // gated by run_tick, which is mutually exclusive with set mode.
  logic sec_wrap;
  logic min_wrap;
  logic hr_wrap;
  logic min_inc;
  logic hr_inc;

  assign min_inc = (run_tick & sec_wrap) | (set_on & press[0]);
  assign hr_inc  = (run_tick & sec_wrap & min_wrap) | (set_on & press[1]);

  // Seconds are held at 00 for the whole time set mode is active.
  bcd_mod_counter #(.RST_VAL(8'h00)) u_sec (
    .clk      (clk_27Mhz),
    .rst      (rst),
    .inc      (run_tick),
    .load     (set_on),
    .load_val (8'h00),
    .max      (SEC_MAX),
    .min_val  (8'h00),
    .val      (sec_bcd),
    .wrap     (sec_wrap)
  );

  bcd_mod_counter #(.RST_VAL(8'h00)) u_min (
    .clk      (clk_27Mhz),
    .rst      (rst),
    .inc      (min_inc),
    .load     (1'b0),
    .load_val (8'h00),
    .max      (MIN_MAX),
    .min_val  (8'h00),
    .val      (min_bcd),
    .wrap     (min_wrap)
  );

  bcd_mod_counter #(.RST_VAL(HR_RST)) u_hr (
    .clk      (clk_27Mhz),
    .rst      (rst),
    .inc      (hr_inc),
    .load     (1'b0),
    .load_val (8'h00),
    .max      (HR_MAX),
    .min_val  (HR_MIN),
    .val      (hr_bcd),
    .wrap     (hr_wrap)
  );

  // sec_tick lines up with the edge that makes the new seconds value visible.
  always_ff @(posedge clk_27Mhz or posedge rst) begin
    if (rst) sec_tick <= 1'b0;
    else     sec_tick <= run_tick;
  end

`ifdef TWELVE_HOUR_EN
  // pm flips on every 11 -> 12 step, whether from a carry or a button press.
  logic pm_q;

  always_ff @(posedge clk_27Mhz or posedge rst) begin
    if (rst)                             pm_q <= 1'b0;
    else if (hr_inc && hr_bcd == 8'h11)  pm_q <= ~pm_q;
  end

  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_watch_time_counter.sv
module tb_watch_time_counter;

  logic       clk_27Mhz = 1'b0;
  logic       rst;
  logic       tick_lvl;
  logic       set_mode;
  logic       inc_min;
  logic       inc_hr;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hr_bcd;
  logic       sec_tick;
  logic       pm;

  int checks    = 0;
  int errors    = 0;
  int tick_seen = 0;

  // Reference model: plain integers for the time of day.
  int m_h, m_m, m_s;
  bit m_pm, m_set;

`ifdef TWELVE_HOUR_EN
  localparam int HR_TOP = 11;
  localparam logic [23:0] RST_TIME = 24'h120000;
`else
  localparam int HR_TOP = 23;
  localparam logic [23:0] RST_TIME = 24'h000000;
`endif

  always #5 clk_27Mhz = ~clk_27Mhz;

  watch_time_counter #(.DEBOUNCE_CYCLES(4), .DB_W(19)) dut (
    .clk_27Mhz (clk_27Mhz),
    .rst       (rst),
    .tick_lvl  (tick_lvl),
    .set_mode  (set_mode),
    .inc_min   (inc_min),
    .inc_hr    (inc_hr),
    .sec_bcd   (sec_bcd),
    .min_bcd   (min_bcd),
    .hr_bcd    (hr_bcd),
    .sec_tick  (sec_tick),
    .pm        (pm)
  );

  always @(negedge clk_27Mhz) if (rst === 1'b0 && sec_tick === 1'b1) tick_seen++;

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [23:0] exp_time();
    return {bcd(m_h), bcd(m_m), bcd(m_s)};
  endfunction

  function automatic void model_reset();
`ifdef TWELVE_HOUR_EN
    m_h = 12;
`else
    m_h = 0;
`endif
    m_m = 0; m_s = 0; m_pm = 0;
  endfunction

  function automatic void model_hr_inc();
`ifdef TWELVE_HOUR_EN
    m_h = (m_h == 12) ? 1 : m_h + 1;
    if (m_h == 12) m_pm = !m_pm;
`else
    m_h = (m_h + 1) % 24;
`endif
  endfunction

  function automatic void model_tick();
    m_s = m_s + 1;
    if (m_s == 60) begin
      m_s = 0;
      m_m = m_m + 1;
      if (m_m == 60) begin
        m_m = 0;
        model_hr_inc();
      end
    end
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_27Mhz);
    #1;
  endtask

  task automatic tick_pulse(input int hi, input int lo);
    tick_lvl = 1'b1; cycles(hi);
    tick_lvl = 1'b0; cycles(lo);
    if (!m_set) model_tick();
  endtask

  task automatic press(input bit dm, input bit dh, input int hi, input int lo);
    inc_min = dm; inc_hr = dh; cycles(hi);
    inc_min = 1'b0; inc_hr = 1'b0; cycles(lo);
    if (m_set) begin
      if (dm) m_m = (m_m + 1) % 60;
      if (dh) model_hr_inc();
    end
  endtask

  task automatic enter_set();
    set_mode = 1'b1; cycles(4);
    m_set = 1; m_s = 0;
  endtask

  task automatic exit_set();
    set_mode = 1'b0; cycles(4);
    m_set = 0;
  endtask

  task automatic set_time_to(input int h, input int mins);
    while (m_m != mins) press(1'b1, 1'b0, $urandom_range(6, 10), $urandom_range(8, 12));
    while (m_h != h)    press(1'b0, 1'b1, $urandom_range(6, 10), $urandom_range(8, 12));
  endtask

  task automatic test_reset();
    rst = 1'b1; tick_lvl = 0; set_mode = 0; inc_min = 0; inc_hr = 0;
    model_reset(); m_set = 0;
    cycles(3);
    checks++; if ({hr_bcd, min_bcd, sec_bcd} !== RST_TIME) begin errors++; $display("FAIL reset_time: got %h expected %h", {hr_bcd, min_bcd, sec_bcd}, RST_TIME); end
    checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL reset_sec_tick: got %b expected 0", sec_tick); end
    checks++; if (pm !== 1'b0) begin errors++; $display("FAIL reset_pm: got %b expected 0", pm); end
    rst = 1'b0; cycles(5);
    checks++; if ({hr_bcd, min_bcd, sec_bcd} !== exp_time()) begin errors++; $display("FAIL post_reset_idle: got %h expected %h", {hr_bcd, min_bcd, sec_bcd}, exp_time()); end
  endtask

  task automatic test_minute_rollover();
    int t0;
    t0 = tick_seen;
    for (int i = 0; i < 60; i++) begin
      tick_pulse(8, 8);
      checks++; if ({hr_bcd, min_bcd, sec_bcd} !== exp_time()) begin errors++; $display("FAIL rollover_step%0d: got %h expected %h", i, {hr_bcd, min_bcd, sec_bcd}, exp_time()); end
    end
    checks++; if (min_bcd !== 8'h01 || sec_bcd !== 8'h00) begin errors++; $display("FAIL rollover_min: got %h:%h expected 01:00", min_bcd, sec_bcd); end
    checks++; if (tick_seen - t0 !== 60) begin errors++; $display("FAIL rollover_tick_count: got %0d expected 60", tick_seen - t0); end
  endtask

  task automatic test_full_carry();
    logic [23:0] old_t, new_t, v;
    int bad, t0;
    enter_set();
    checks++; if (sec_bcd !== 8'h00) begin errors++; $display("FAIL set_entry_sec: got %h expected 00", sec_bcd); end
    set_time_to(HR_TOP, 59);
    exit_set();
    for (int i = 0; i < 59; i++) tick_pulse($urandom_range(2, 6), $urandom_range(3, 8));
    checks++; if ({hr_bcd, min_bcd, sec_bcd} !== exp_time() || pm !== m_pm) begin errors++; $display("FAIL carry_preload: got %h pm %b expected %h pm %b", {hr_bcd, min_bcd, sec_bcd}, pm, exp_time(), m_pm); end
    old_t = exp_time();
    model_tick();
    new_t = exp_time();
    bad = 0; t0 = tick_seen;
    tick_lvl = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_27Mhz);
      v = {hr_bcd, min_bcd, sec_bcd};
      if (v !== old_t && v !== new_t) bad++;
    end
    @(posedge clk_27Mhz); #1 tick_lvl = 1'b0;
    cycles(4);
    checks++; if (bad !== 0) begin errors++; $display("FAIL carry_intermediate: got %0d odd samples expected 0", bad); end
    checks++; if ({hr_bcd, min_bcd, sec_bcd} !== RST_TIME) begin errors++; $display("FAIL carry_result: got %h expected %h", {hr_bcd, min_bcd, sec_bcd}, RST_TIME); end
    checks++; if (pm !== m_pm) begin errors++; $display("FAIL carry_pm: got %b expected %b", pm, m_pm); end
    checks++; if (tick_seen - t0 !== 1) begin errors++; $display("FAIL carry_tick_count: got %0d expected 1", tick_seen - t0); end
  endtask

  task automatic test_long_high();
    int first, cnt;
    first = -1; cnt = 0;
    tick_lvl = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk_27Mhz);
      if (sec_tick === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    @(posedge clk_27Mhz); #1 tick_lvl = 1'b0;
    cycles(6);
    model_tick();
    checks++; if (cnt !== 1) begin errors++; $display("FAIL long_high_pulses: got %0d expected 1", cnt); end
    checks++; if (first !== 4) begin errors++; $display("FAIL long_high_latency: got sample %0d expected 4", first); end
    checks++; if ({hr_bcd, min_bcd, sec_bcd} !== exp_time()) begin errors++; $display("FAIL long_high_time: got %h expected %h", {hr_bcd, min_bcd, sec_bcd}, exp_time()); end
  endtask

  task automatic test_set_mode();
    int t0;
    for (int i = 0; i < 5; i++) tick_pulse($urandom_range(2, 6), $urandom_range(3, 8));
    enter_set();
    checks++; if (sec_bcd !== 8'h00) begin errors++; $display("FAIL set_sec_clear: got %h expected 00", sec_bcd); end
    set_time_to(m_h, 59);
    press(1'b1, 1'b0, 8, 10);
    checks++; if (min_bcd !== 8'h00) begin errors++; $display("FAIL set_min_wrap: got %h expected 00", min_bcd); end
    checks++; if (hr_bcd !== bcd(m_h)) begin errors++; $display("FAIL set_min_no_carry: got %h expected %h", hr_bcd, bcd(m_h)); end
    inc_hr = 1'b1; cycles(3); inc_hr = 1'b0; cycles(20);
    checks++; if ({hr_bcd, min_bcd, sec_bcd} !== exp_time()) begin errors++; $display("FAIL set_glitch: got %h expected %h", {hr_bcd, min_bcd, sec_bcd}, exp_time()); end
    t0 = tick_seen;
    for (int i = 0; i < 6; i++) tick_pulse($urandom_range(2, 8), $urandom_range(3, 8));
    checks++; if (tick_seen !== t0) begin errors++; $display("FAIL set_tick_pulse: got %0d pulses expected 0", tick_seen - t0); end
    checks++; if (sec_bcd !== 8'h00) begin errors++; $display("FAIL set_sec_held: got %h expected 00", sec_bcd); end
    press(1'b1, 1'b1, 8, 10);
    checks++; if ({hr_bcd, min_bcd, sec_bcd} !== exp_time() || pm !== m_pm) begin errors++; $display("FAIL set_both_press: got %h pm %b expected %h pm %b", {hr_bcd, min_bcd, sec_bcd}, pm, exp_time(), m_pm); end
    exit_set();
    press(1'b1, 1'b0, $urandom_range(6, 10), 10);
    press(1'b0, 1'b1, $urandom_range(6, 10), 10);
    checks++; if ({hr_bcd, min_bcd, sec_bcd} !== exp_time()) begin errors++; $display("FAIL run_press_ignored: got %h expected %h", {hr_bcd, min_bcd, sec_bcd}, exp_time()); end
    tick_pulse(4, 6);
    checks++; if (sec_bcd !== 8'h01) begin errors++; $display("FAIL resume_from_00: got %h expected 01", sec_bcd); end
  endtask

  task automatic test_reset_mid();
    enter_set();
    set_time_to(10, 42);
    exit_set();
    while (m_s != 17) tick_pulse($urandom_range(2, 5), $urandom_range(3, 6));
    checks++; if ({hr_bcd, min_bcd, sec_bcd} !== 24'h104217) begin errors++; $display("FAIL mid_preload: got %h expected 104217", {hr_bcd, min_bcd, sec_bcd}); end
    set_mode = 1'b1; inc_min = 1'b1;
    @(posedge clk_27Mhz); @(posedge clk_27Mhz);
    #2 rst = 1'b1;
    #1;
    checks++; if ({hr_bcd, min_bcd, sec_bcd} !== RST_TIME) begin errors++; $display("FAIL async_reset: got %h expected %h", {hr_bcd, min_bcd, sec_bcd}, RST_TIME); end
    inc_min = 1'b0;
    model_reset(); m_set = 1;
    cycles(2);
    rst = 1'b0;
    cycles(30);
    checks++; if ({hr_bcd, min_bcd, sec_bcd} !== RST_TIME || pm !== 1'b0) begin errors++; $display("FAIL no_pending_press: got %h pm %b expected %h pm 0", {hr_bcd, min_bcd, sec_bcd}, pm, RST_TIME); end
    exit_set();
  endtask

  initial begin
    test_reset();
    test_minute_rollover();
    test_full_carry();
    test_long_high();
    test_set_mode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
